// File: rtl/ln_stream_module_if.sv
// rtl/ln_stream_module_if.sv - row stream, 1/sqrt handshake and debug bundle for ln_stream_module
interface ln_stream_module_if #(
  parameter int LANES = 8,
  parameter int DW    = 16
);
  logic                mode;
  logic                in_valid;
  logic                in_ready;
  logic [LANES*DW-1:0] in_data;
  logic                rsq_req_valid;
  logic                rsq_req_ready;
  logic [DW-1:0]       rsq_var;
  logic                rsq_resp_valid;
  logic [DW-1:0]       rsq_inv_std;
  logic                out_valid;
  logic                out_ready;
  logic [LANES*DW-1:0] out_data;
  logic                out_last;
  logic [DW-1:0]       mu_out;
  logic [DW-1:0]       var_out;
  logic [DW-1:0]       inv_std_out;

  modport master (
    output mode, in_valid, in_data, rsq_req_ready, rsq_resp_valid, rsq_inv_std, out_ready,
    input  in_ready, rsq_req_valid, rsq_var, out_valid, out_data, out_last,
           mu_out, var_out, inv_std_out
  );

  modport slave (
    input  mode, in_valid, in_data, rsq_req_ready, rsq_resp_valid, rsq_inv_std, out_ready,
    output in_ready, rsq_req_valid, rsq_var, out_valid, out_data, out_last,
           mu_out, var_out, inv_std_out
  );
endinterface

// File: rtl/ln_stream_module.sv
// rtl/ln_stream_module.sv - streaming LayerNorm/RMSNorm with row buffer and external 1/sqrt handshake
module ln_stream_module #(
  parameter int N     = 64,
  parameter int LANES = 8,
  parameter int DW    = 16,
  parameter int FRAC  = 8
) (
  input logic               clk,
  input logic               rst,
  ln_stream_module_if.slave bus
);
  localparam int LOGN  = $clog2(N);
  localparam int BEATS = N / LANES;
  localparam int CW    = $clog2(BEATS);
  localparam int SW    = DW + LOGN;
  localparam int QW    = 2 * DW + LOGN;
  localparam int PW    = 2 * DW + 2;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);
  localparam logic [DW-1:0] SMAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] SMIN = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic [2:0] {LOAD, CALC, RSQ_REQ, RSQ_WAIT, OUT} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [SW-1:0]   sum;
  logic [QW-1:0]   sumsq;
  logic [DW-1:0]   mu;
  logic [DW-1:0]   var_q;
  logic [DW-1:0]   inv_std;
  logic            mode_q;
  logic [DW-1:0]   row_mem [BEATS][LANES];

  logic [SW-1:0]       beat_sum;
  logic [QW-1:0]       beat_sumsq;
  logic [DW-1:0]       mu_c;
  logic [2*DW-1:0]     mu_sq;
  logic [2*DW+1:0]     v_full;
  logic [2*DW+1:0]     v_sh;
  logic [DW-1:0]       var_c;
  logic [LANES*DW-1:0] out_data_c;

  function automatic logic [2*DW-1:0] square(input logic [DW-1:0] x);
    logic signed [2*DW-1:0] xe;
    xe = {{DW{x[DW-1]}}, x};
    return xe * xe;
  endfunction

  // (x - mu) * inv_std >>> FRAC, saturated back to DW bits
  function automatic logic [DW-1:0] lane_norm(input logic [DW-1:0] x, input logic [DW-1:0] m,
                                              input logic [DW-1:0] s);
    logic signed [DW:0]   diff;
    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] sh;
    diff = $signed({x[DW-1], x}) - $signed({m[DW-1], m});
    prod = $signed({{(DW+1){diff[DW]}}, diff}) * $signed({{(DW+2){1'b0}}, s});
    sh   = prod >>> FRAC;
    if ((&sh[PW-1:DW-1]) || !(|sh[PW-1:DW-1])) return sh[DW-1:0];
    return sh[PW-1] ? SMIN : SMAX;
  endfunction

  always_comb begin
    beat_sum   = '0;
    beat_sumsq = '0;
    for (int i = 0; i < LANES; i++) begin
      beat_sum   = beat_sum + {{LOGN{bus.in_data[i*DW+DW-1]}}, bus.in_data[i*DW +: DW]};
      beat_sumsq = beat_sumsq + {{LOGN{1'b0}}, square(bus.in_data[i*DW +: DW])};
    end
  end

  // Top bits of the accumulators are the divide-by-N results.
  always_comb begin
    mu_c   = mode_q ? '0 : sum[LOGN +: DW];
    mu_sq  = square(mu_c);
    v_full = {2'b00, sumsq[LOGN +: 2*DW]} - {2'b00, mu_sq};
    v_sh   = v_full >> FRAC;
    var_c  = '0;
    if (!v_full[2*DW+1]) var_c = (|v_sh[2*DW+1:DW-1]) ? SMAX : v_sh[DW-1:0];
  end

  always_ff @(posedge clk) begin
    if (state == LOAD && bus.in_valid) begin
      for (int i = 0; i < LANES; i++) row_mem[cnt][i] <= bus.in_data[i*DW +: DW];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= LOAD;
      cnt     <= '0;
      sum     <= '0;
      sumsq   <= '0;
      mu      <= '0;
      var_q   <= '0;
      inv_std <= '0;
      mode_q  <= 1'b0;
    end else begin
      case (state)
        LOAD: if (bus.in_valid) begin
          if (cnt == '0) mode_q <= bus.mode;
          sum   <= sum + beat_sum;
          sumsq <= sumsq + beat_sumsq;
          if (cnt == LAST_BEAT) begin
            cnt   <= '0;
            state <= CALC;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        CALC: begin
          mu    <= mu_c;
          var_q <= var_c;
          sum   <= '0;
          sumsq <= '0;
          cnt   <= '0;
          state <= RSQ_REQ;
        end
        RSQ_REQ: if (bus.rsq_req_ready) state <= RSQ_WAIT;
        RSQ_WAIT: if (bus.rsq_resp_valid) begin
          inv_std <= bus.rsq_inv_std;
          state   <= OUT;
        end
        OUT: if (bus.out_ready) begin
          if (cnt == LAST_BEAT) begin
            cnt   <= '0;
            state <= LOAD;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

  // Output lanes read straight from the buffer, so they hold while the counter is stalled.
  always_comb begin
    out_data_c = '0;
    if (state == OUT) begin
      for (int i = 0; i < LANES; i++) out_data_c[i*DW +: DW] = lane_norm(row_mem[cnt][i], mu, inv_std);
    end
  end

  assign bus.in_ready      = (state == LOAD);
  assign bus.rsq_req_valid = (state == RSQ_REQ);
  assign bus.rsq_var       = var_q;
  assign bus.out_valid     = (state == OUT);
  assign bus.out_last      = (state == OUT) && (cnt == LAST_BEAT);
  assign bus.out_data      = out_data_c;
  assign bus.mu_out        = mu;
  assign bus.var_out       = var_q;
  assign bus.inv_std_out   = inv_std;
endmodule

// File: tb/tb_ln_stream_module.sv
// tb/tb_ln_stream_module.sv - scoreboard bench for ln_stream_module with N=8, LANES=4, DW=16, FRAC=8
module tb_ln_stream_module;
  typedef struct packed {
    logic [63:0] data;
    logic        last;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  int   n_asserts;
  int   n_fail;
  beat_t sb[$];
  logic [15:0] row [8];

  always #5 clk = ~clk;

  ln_stream_module_if #(.LANES(4), .DW(16)) bus ();

  ln_stream_module #(.N(8), .LANES(4), .DW(16), .FRAC(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic longint fdiv(input longint a, input longint d);
    if (a >= 0) return a / d;
    return -((-a + d - 1) / d);
  endfunction

  function automatic logic [15:0] sat16(input longint v);
    if (v > 32767) return 16'h7FFF;
    if (v < -32768) return 16'h8000;
    return v[15:0];
  endfunction

  task automatic check_idle(input string tag);
    chk({tag, "_in_ready"}, bus.in_ready, 1);
    chk({tag, "_req_valid"}, bus.rsq_req_valid, 0);
    chk({tag, "_out_valid"}, bus.out_valid, 0);
    chk({tag, "_out_last"}, bus.out_last, 0);
    chk({tag, "_out_data"}, bus.out_data, 0);
    chk({tag, "_rsq_var"}, bus.rsq_var, 0);
    chk({tag, "_mu_out"}, bus.mu_out, 0);
    chk({tag, "_var_out"}, bus.var_out, 0);
    chk({tag, "_inv_std_out"}, bus.inv_std_out, 0);
  endtask

  task automatic run_row(input logic [15:0] el [8], input logic m, input logic [15:0] inv,
                         input logic [15:0] exp_mu, input logic [15:0] exp_var,
                         input int stall, input bit rand_rdy, input bit rst_in_out);
    beat_t       e;
    longint      s;
    longint      mu_m;
    logic [63:0] held;
    logic        held_last;
    bit          stalled;
    int          beats;
    int          t;
    s = 0;
    for (int i = 0; i < 8; i++) s += longint'($signed(el[i]));
    mu_m = m ? 0 : fdiv(s, 8);
    for (int b = 0; b < 2; b++) begin
      e.data = '0;
      for (int l = 0; l < 4; l++)
        e.data[l*16 +: 16] = sat16(fdiv((longint'($signed(el[b*4+l])) - mu_m) * longint'(inv), 256));
      e.last = (b == 1);
      sb.push_back(e);
    end

    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      chk("in_ready_load", bus.in_ready, 1);
      bus.in_valid = 1'b1;
      bus.mode     = (b == 0) ? m : ~m;
      for (int l = 0; l < 4; l++) bus.in_data[l*16 +: 16] = el[b*4+l];
    end
    @(negedge clk);
    bus.in_data = '1;
    chk("in_ready_calc", bus.in_ready, 0);
    chk("req_early", bus.rsq_req_valid, 0);
    @(negedge clk);
    chk("req_latency", bus.rsq_req_valid, 1);
    t = 0;
    while (!bus.rsq_req_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("rsq_var", bus.rsq_var, exp_var);
    chk("mu_out", bus.mu_out, exp_mu);
    chk("var_out", bus.var_out, exp_var);
    held = bus.rsq_var;
    repeat (stall) begin
      @(negedge clk);
      chk("rsq_var_stable", bus.rsq_var, held);
      chk("req_held", bus.rsq_req_valid, 1);
      chk("in_ready_req", bus.in_ready, 0);
    end
    bus.rsq_req_ready = 1'b1;
    @(negedge clk);
    bus.rsq_req_ready = 1'b0;
    chk("req_done", bus.rsq_req_valid, 0);
    repeat (2) @(negedge clk);
    chk("wait_no_out", bus.out_valid, 0);
    bus.rsq_resp_valid = 1'b1;
    bus.rsq_inv_std    = inv;
    @(negedge clk);
    bus.rsq_resp_valid = 1'b0;
    bus.in_valid       = 1'b0;
    chk("out_latency", bus.out_valid, 1);
    chk("inv_std_out", bus.inv_std_out, inv);

    beats   = 0;
    stalled = 0;
    t       = 0;
    while (beats < 2 && t < 200) begin
      bus.out_ready = 1'b0;
      if (bus.out_valid) begin
        if (rst_in_out) begin
          rst = 1'b1;
          @(negedge clk);
          rst = 1'b0;
          check_idle("rst_out");
          sb.delete();
          return;
        end
        chk("in_ready_out", bus.in_ready, 0);
        if (stalled) begin
          chk("out_data_stable", bus.out_data, held);
          chk("out_last_stable", bus.out_last, held_last);
        end
        bus.out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        if (bus.out_ready) begin
          chk("sb_nonempty", sb.size() != 0, 1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("out_data", bus.out_data, e.data);
            chk("out_last", bus.out_last, e.last);
          end
          beats++;
          stalled = 0;
        end else begin
          stalled   = 1;
          held      = bus.out_data;
          held_last = bus.out_last;
        end
      end
      @(negedge clk);
      t++;
    end
    bus.out_ready = 1'b0;
    chk("beat_count", beats, 2);
    chk("no_extra_beat", bus.out_valid, 0);
    chk("in_ready_after", bus.in_ready, 1);
  endtask

  initial begin
    n_asserts          = 0;
    n_fail             = 0;
    rst                = 1'b1;
    bus.mode           = 1'b0;
    bus.in_valid       = 1'b0;
    bus.in_data        = '0;
    bus.rsq_req_ready  = 1'b0;
    bus.rsq_resp_valid = 1'b0;
    bus.rsq_inv_std    = '0;
    bus.out_ready      = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_idle("reset");

    for (int i = 0; i < 8; i++) row[i] = 16'h0100;
    run_row(row, 1'b0, 16'h0100, 16'h0100, 16'h0000, 0, 0, 0);

    for (int i = 0; i < 8; i++) row[i] = (i % 2 == 0) ? 16'h0100 : 16'hFF00;
    run_row(row, 1'b0, 16'h0100, 16'h0000, 16'h0100, 0, 0, 0);

    for (int i = 0; i < 8; i++) row[i] = 16'h0200;
    run_row(row, 1'b1, 16'h0080, 16'h0000, 16'h0400, 0, 0, 0);

    for (int i = 0; i < 8; i++) row[i] = (i % 2 == 0) ? 16'h7FFF : 16'h8000;
    run_row(row, 1'b0, 16'h0400, 16'hFFFF, 16'h7FFF, 0, 0, 0);

    for (int i = 0; i < 8; i++) row[i] = (i % 2 == 0) ? 16'h0100 : 16'hFF00;
    run_row(row, 1'b0, 16'h0100, 16'h0000, 16'h0100, 5, 1, 0);
    for (int i = 0; i < 8; i++) row[i] = 16'(i * 64 - 256);
    run_row(row, 1'b0, 16'h0100, 16'hFFE0, 16'h0054, 5, 1, 0);

    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = {16'h0040, 16'h0030, 16'h0020, 16'h0010};
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst          = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle("rst_row");
    for (int i = 0; i < 8; i++) row[i] = (i % 2 == 0) ? 16'h0100 : 16'hFF00;
    run_row(row, 1'b0, 16'h0100, 16'h0000, 16'h0100, 0, 0, 0);

    run_row(row, 1'b0, 16'h0100, 16'h0000, 16'h0100, 0, 0, 1);
    run_row(row, 1'b0, 16'h0100, 16'h0000, 16'h0100, 2, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule
